// File: rtl/pwm_multi.sv
// pwm_multi: shared-counter multi-channel PWM with edge/centre modes and boundary-synchronised double-buffered duty/period.
module pwm_multi #(
  parameter int CBITS = 11,
  parameter int CHANNELS = 3,
  parameter logic [CBITS-1:0] PERIOD_RST = '1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         center,
  input  logic                         load,
  input  logic [CBITS-1:0]             period_in,
  input  logic [CHANNELS*CBITS-1:0]    duty_in,
  output logic [CHANNELS-1:0]          pulse,
  output logic                         period_start,
  output logic                         pending
);
  logic [CBITS-1:0] r_cnt, r_per_act, r_per_shd;
  logic [CHANNELS*CBITS-1:0] r_duty_act, r_duty_shd;
  logic r_down, r_mode, r_fresh;
  logic w_wrap, w_down_nxt;
  logic [CBITS-1:0] w_cnt_nxt;
  logic [CHANNELS-1:0] w_pulse;
  // r_down means the next step is a decrement; it is set on reaching the top so the turn-around sample is counted once
  always_comb begin
    w_wrap = r_mode ? (r_per_act == '0 || (r_down && r_cnt == CBITS'(1))) : r_cnt == r_per_act;
    w_cnt_nxt = w_wrap ? '0 : (r_mode && r_down) ? r_cnt - 1'b1 : r_cnt + 1'b1;
    w_down_nxt = w_wrap ? 1'b0 : (r_mode && w_cnt_nxt == r_per_act) ? 1'b1 : r_down;
  end
  for (genvar g = 0; g < CHANNELS; g++) begin : g_cmp
    assign w_pulse[g] = r_cnt < r_duty_act[g*CBITS +: CBITS];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_down <= 1'b0;
      r_per_act <= PERIOD_RST;
      r_per_shd <= PERIOD_RST;
      r_duty_act <= '0;
      r_duty_shd <= '0;
      r_mode <= 1'b0;
      r_fresh <= 1'b1;
      pulse <= '0;
      period_start <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (en) begin
        r_cnt <= w_cnt_nxt;
        r_down <= w_down_nxt;
        pulse <= w_pulse;
        period_start <= w_wrap | r_fresh;
        r_fresh <= 1'b0;
      end else begin
        pulse <= '0;
        period_start <= 1'b0;
      end
      if (en && w_wrap) begin
        r_mode <= center;
        pending <= 1'b0;
        if (load || pending) begin
          r_per_act <= load ? period_in : r_per_shd;
          r_duty_act <= load ? duty_in : r_duty_shd;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
      if (load) begin
        r_per_shd <= period_in;
        r_duty_shd <= duty_in;
      end
    end
  end
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: phase-based reference model feeding a scoreboard queue checked every cycle by a monitor.
module tb_pwm_multi;
  localparam int CB = 11, CH = 3, PR = 2**CB - 1;
  logic clk = 1'b0, rst, en, center, load;
  logic [CB-1:0] period_in;
  logic [CH*CB-1:0] duty_in;
  logic [CH-1:0] pulse;
  logic period_start, pending;
  always #5 clk = ~clk;
  pwm_multi #(.CBITS(CB), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .en(en), .center(center), .load(load),
    .period_in(period_in), .duty_in(duty_in),
    .pulse(pulse), .period_start(period_start), .pending(pending)
  );
  typedef struct packed {logic [CH-1:0] pulse; logic ps; logic pend;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0;
  int m_p, m_per, m_sper, m_mode, m_pend, m_fresh;
  int m_duty[CH], m_sduty[CH];
  function automatic int m_len();
    return m_mode != 0 ? (m_per == 0 ? 1 : 2 * m_per) : m_per + 1;
  endfunction
  function automatic int m_cnt();
    return (m_mode != 0 && m_p > m_per) ? 2 * m_per - m_p : m_p;
  endfunction
  task automatic capture();
    m_sper = int'(period_in);
    for (int i = 0; i < CH; i++) m_sduty[i] = int'(duty_in[i*CB +: CB]);
    m_pend = 1;
  endtask
  always @(posedge clk) begin
    exp_t e;
    int c;
    bit w;
    e = '0;
    cyc++;
    if (rst) begin
      m_p = 0; m_per = PR; m_sper = PR; m_mode = 0; m_pend = 0; m_fresh = 1;
      for (int i = 0; i < CH; i++) begin m_duty[i] = 0; m_sduty[i] = 0; end
    end else if (en) begin
      c = m_cnt();
      for (int i = 0; i < CH; i++) e.pulse[i] = c < m_duty[i];
      w = (m_p == m_len() - 1);
      e.ps = w || m_fresh != 0;
      m_fresh = 0;
      m_p = w ? 0 : m_p + 1;
      if (w) begin
        m_mode = int'(center);
        if (load) begin
          capture();
          m_pend = 0;
        end
        if (load || m_pend != 0) begin
          m_per = m_sper;
          for (int i = 0; i < CH; i++) m_duty[i] = m_sduty[i];
          m_pend = 0;
        end
      end else if (load) capture();
    end else if (load) capture();
    e.pend = m_pend != 0;
    q.push_back(e);
  end
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({pulse, period_start, pending} !== e) begin
        failures++;
        $display("FAIL outputs cyc=%0d got pulse=%b ps=%b pend=%b exp pulse=%b ps=%b pend=%b",
                 cyc, pulse, period_start, pending, e.pulse, e.ps, e.pend);
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic ld(input int per, input int d0, input int d1, input int d2);
    period_in = CB'(per);
    duty_in = {CB'(d2), CB'(d1), CB'(d0)};
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask
  task automatic waitp(input int t);
    for (int k = 0; k < 5000 && m_p != t; k++) @(negedge clk);
    checks++;
    if (m_p != t) begin
      failures++;
      $display("FAIL wait_phase got=%0d exp=%0d", m_p, t);
    end
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; center = 1'b0; load = 1'b0; period_in = '0; duty_in = '0;
    step(2);
    rst = 1'b0; en = 1'b1;
    ld(PR, 128, 0, 0);
    step(4200);
    ld(9, 0, 5, 15);
    step(40);
    center = 1'b1;
    ld(8, 3, 3, 3);
    step(60);
    center = 1'b0;
    ld(9, 1, 1, 1);
    step(40);
    waitp(3);
    ld(9, 2, 2, 2);
    step(2);
    ld(9, 7, 7, 7);
    step(30);
    waitp(m_len() - 1);
    ld(9, 4, 6, 8);
    step(30);
    ld(9, 9, 9, 9);
    step(25);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(20);
    ld(5, 3, 3, 3);
    step(3000);
    en = 1'b0;
    step(5);
    ld(5, 1, 2, 3);
    step(10);
    en = 1'b1;
    step(20);
    repeat (3000) begin
      int per;
      rst = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 9) != 0);
      center = $urandom_range(0, 1) != 0;
      load = 1'b0;
      if ($urandom_range(0, 14) == 0) begin
        per = $urandom_range(0, 12);
        period_in = CB'(per);
        duty_in = {CB'($urandom_range(0, per + 2)), CB'($urandom_range(0, per + 2)), CB'($urandom_range(0, per + 2))};
        load = 1'b1;
      end
      step(1);
    end
    rst = 1'b0; load = 1'b0;
    step(3);
    checks++;
    if (q.size() > 2) begin
      failures++;
      $display("FAIL queue_drain got=%0d exp<=2", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
